// File: rtl/setting_manager_pkg.sv
// rtl/setting_manager_pkg.sv - FSM state encoding and counter-width helper
package setting_manager_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT, ST_LOCK} state_t;

  // Bits needed to hold a counter running 0..n-1 (never less than 1).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/setting_manager_key.sv
// rtl/setting_manager_key.sv - key_debouncer: 2-flop synchronizer plus tick-based debounce
module key_debouncer
  import setting_manager_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic key,
  input  logic tick,
  output logic level
);

  localparam int CW = clog2(DEBOUNCE_TICKS);

  logic          sync1, sync2, deb;
  logic [CW-1:0] cnt;
  logic          flip;

  // The new level is presented during the flipping tick so the FSM can act on the same edge.
  assign flip  = tick && (sync2 != deb) && (cnt == CW'(DEBOUNCE_TICKS - 1));
  assign level = flip ? sync2 : deb;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (tick) begin
        if (sync2 == deb || flip) cnt <= '0;
        else                      cnt <= cnt + CW'(1);
        if (flip) deb <= sync2;
      end
    end
  end

endmodule

// File: rtl/setting_manager.sv
// rtl/setting_manager.sv - two-button setting register with debounce, auto-repeat, restore and load
module setting_manager
  import setting_manager_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int MIN_VAL        = 0,
  parameter int MAX_VAL        = 255,
  parameter int DEFAULT_VAL    = 255,
  parameter int STEP           = 1,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100,
  parameter int WRAP           = 0
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             INC_KEY,
  input  logic             DEC_KEY,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] value,
  output logic             at_min,
  output logic             at_max,
  output logic             changed
);

  localparam int XW = WIDTH + 1;
  localparam int PW = clog2(TICK_DIV);
  localparam int RW = clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [XW-1:0]    MAX_X  = XW'(MAX_VAL);
  localparam logic [XW-1:0]    MIN_X  = XW'(MIN_VAL);
  localparam logic [XW-1:0]    STEP_X = XW'(STEP);
  localparam logic [XW-1:0]    LOW_X  = XW'(MIN_VAL + STEP);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEFAULT_VAL);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic             inc_lvl, dec_lvl, inc_p, dec_p;
  state_t           state;
  logic             dir_up;
  logic [RW-1:0]    rcnt, rep_lim;
  logic [WIDTH-1:0] value_prev, up_val, dn_val, load_clamp;
  logic [XW-1:0]    val_x, sum_x;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) pre_cnt <= '0;
    else          pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
  end

  key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_inc (
    .clk(clk), .RESET_N(RESET_N), .key(INC_KEY), .tick(tick), .level(inc_lvl)
  );
  key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dec (
    .clk(clk), .RESET_N(RESET_N), .key(DEC_KEY), .tick(tick), .level(dec_lvl)
  );

  assign inc_p = !inc_lvl;
  assign dec_p = !dec_lvl;

  // One extra bit keeps value+STEP from overflowing before the range compare.
  assign val_x = {1'b0, value};
  assign sum_x = val_x + STEP_X;

  always_comb begin
    up_val = sum_x[WIDTH-1:0];
    if (sum_x > MAX_X) up_val = (WRAP != 0 && value == MAX_W) ? MIN_W : MAX_W;
    dn_val = value - STEP_W;
    if (val_x < LOW_X) dn_val = (WRAP != 0 && value == MIN_W) ? MAX_W : MIN_W;
    load_clamp = LOAD_VAL;
    if ({1'b0, LOAD_VAL} < MIN_X)      load_clamp = MIN_W;
    else if ({1'b0, LOAD_VAL} > MAX_X) load_clamp = MAX_W;
  end

  assign rep_lim = (state == ST_WAIT) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      dir_up     <= 1'b0;
      rcnt       <= '0;
      value      <= DEF_W;
      value_prev <= DEF_W;
    end else begin
      value_prev <= value;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (inc_p && dec_p) begin
              value <= DEF_W;
              state <= ST_LOCK;
            end else if (inc_p || dec_p) begin
              value  <= inc_p ? up_val : dn_val;
              dir_up <= inc_p;
              rcnt   <= '0;
              state  <= ST_WAIT;
            end
          end
          ST_WAIT, ST_REPEAT: begin
            if (inc_p && dec_p) begin
              value <= DEF_W;
              state <= ST_LOCK;
            end else if (!(dir_up ? inc_p : dec_p)) begin
              state <= ST_IDLE;
            end else if (rcnt == rep_lim) begin
              value <= dir_up ? up_val : dn_val;
              rcnt  <= '0;
              state <= ST_REPEAT;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
          ST_LOCK: if (!inc_p && !dec_p) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
      // Load overrides any step taken on the same edge; FSM state is left alone.
      if (LOAD) value <= load_clamp;
    end
  end

  assign at_min  = (value == MIN_W);
  assign at_max  = (value == MAX_W);
  assign changed = (value != value_prev);

endmodule

// File: tb/tb_setting_manager.sv
// tb/tb_setting_manager.sv - directed and randomized checks of setting_manager, saturate and wrap variants
module tb_setting_manager;

  localparam int MINV = 10, MAXV = 20, DEFV = 15, STP = 3;
  localparam int TD = 4, DB = 2, RD = 8, RR = 2;

  logic       clk = 1'b0;
  logic       RESET_N = 1'b0;
  logic       INC_KEY = 1'b1;
  logic       DEC_KEY = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] LOAD_VAL = 8'd0;
  logic [7:0] value0, value1;
  logic       at_min0, at_max0, changed0, at_min1, at_max1, changed1;

  int total = 0, bad = 0;
  int ev[2];
  int ecc[2];
  int cc0 = 0, cc1 = 0;
  int tpc = 0;

  always #5 clk = ~clk;

  setting_manager #(.WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .DEFAULT_VAL(DEFV), .STEP(STP),
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(0)) dut0 (
    .clk(clk), .RESET_N(RESET_N), .INC_KEY(INC_KEY), .DEC_KEY(DEC_KEY), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .value(value0), .at_min(at_min0), .at_max(at_max0), .changed(changed0));

  setting_manager #(.WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .DEFAULT_VAL(DEFV), .STEP(STP),
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1)) dut1 (
    .clk(clk), .RESET_N(RESET_N), .INC_KEY(INC_KEY), .DEC_KEY(DEC_KEY), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .value(value1), .at_min(at_min1), .at_max(at_max1), .changed(changed1));

  // Tick timing reference: one tick every TD clocks after reset release.
  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) tpc <= 0;
    else          tpc <= (tpc == TD - 1) ? 0 : tpc + 1;
  end

  always @(negedge clk) begin
    if (changed0) cc0 <= cc0 + 1;
    if (changed1) cc1 <= cc1 + 1;
  end

  function automatic int m_up(int v, bit w);
    if (v + STP > MAXV) return (w && v == MAXV) ? MINV : MAXV;
    return v + STP;
  endfunction

  function automatic int m_dn(int v, bit w);
    if (v < MINV + STP) return (w && v == MINV) ? MAXV : MINV;
    return v - STP;
  endfunction

  function automatic int m_clamp(int v);
    if (v < MINV) return MINV;
    if (v > MAXV) return MAXV;
    return v;
  endfunction

  // Steps produced by a key held for h ticks: first on debounce, then after the delay, then every RR.
  function automatic int n_steps(int h);
    if (h < DB) return 0;
    if (h < 1 + RD) return 1;
    return 2 + (h - 1 - RD) / RR;
  endfunction

  task automatic m_apply(int v0, int v1);
    if (v0 != ev[0]) ecc[0]++;
    if (v1 != ev[1]) ecc[1]++;
    ev[0] = v0;
    ev[1] = v1;
  endtask

  task automatic m_step(bit up);
    m_apply(up ? m_up(ev[0], 1'b0) : m_dn(ev[0], 1'b0), up ? m_up(ev[1], 1'b1) : m_dn(ev[1], 1'b1));
  endtask

  task automatic chk(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".value0"}, int'(value0), ev[0]);
    chk({tag, ".value1"}, int'(value1), ev[1]);
    chk({tag, ".changes0"}, cc0, ecc[0]);
    chk({tag, ".changes1"}, cc1, ecc[1]);
    chk({tag, ".at_min0"}, int'(at_min0), int'(ev[0] == MINV));
    chk({tag, ".at_max0"}, int'(at_max0), int'(ev[0] == MAXV));
    chk({tag, ".at_min1"}, int'(at_min1), int'(ev[1] == MINV));
    chk({tag, ".at_max1"}, int'(at_max1), int'(ev[1] == MAXV));
  endtask

  task automatic tick_wait(int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
        #1;
      end while (tpc != 0);
    end
  endtask

  task automatic tap(bit up, int h);
    tick_wait(1);
    if (up) INC_KEY = 1'b0;
    else    DEC_KEY = 1'b0;
    tick_wait(h);
    INC_KEY = 1'b1;
    DEC_KEY = 1'b1;
    tick_wait(4);
    for (int i = 0; i < n_steps(h); i++) m_step(up);
  endtask

  task automatic do_load(int v);
    tick_wait(1);
    LOAD_VAL = 8'(v);
    LOAD = 1'b1;
    @(posedge clk);
    #1;
    LOAD = 1'b0;
    m_apply(m_clamp(v), m_clamp(v));
    tick_wait(1);
  endtask

  initial begin
    int op, lv;
    ev[0] = DEFV; ev[1] = DEFV;
    ecc[0] = 0;   ecc[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.changed0", int'(changed0), 0);
    RESET_N = 1'b1;

    tap(1'b1, 4);
    check_all("single_inc");

    tap(1'b1, 30);
    check_all("hold_inc");

    do_load(20);
    tap(1'b1, 2);
    check_all("wrap_up");
    tap(1'b0, 2);
    check_all("wrap_dn");

    do_load(12);
    tick_wait(1);
    DEC_KEY = 1'b0;
    tick_wait(4);
    INC_KEY = 1'b0;
    tick_wait(4);
    m_step(1'b0);
    m_apply(DEFV, DEFV);
    chk("lock_restore0", int'(value0), ev[0]);
    chk("lock_restore1", int'(value1), ev[1]);
    INC_KEY = 1'b1;
    tick_wait(6);
    chk("lock_partial0", int'(value0), ev[0]);
    chk("lock_partial1", int'(value1), ev[1]);
    DEC_KEY = 1'b1;
    tick_wait(4);
    check_all("lock_release");
    tap(1'b1, 2);
    check_all("lock_exit");

    do_load(250);
    check_all("load_high");
    do_load(3);
    check_all("load_low");

    tick_wait(1);
    INC_KEY = 1'b0;
    tick_wait(11);
    repeat (3) @(posedge clk);
    #1;
    LOAD_VAL = 8'd14;
    LOAD = 1'b1;
    @(posedge clk);
    #1;
    LOAD = 1'b0;
    INC_KEY = 1'b1;
    m_step(1'b1);
    m_step(1'b1);
    m_apply(14, 14);
    chk("load_vs_step0", int'(value0), ev[0]);
    chk("load_vs_step1", int'(value1), ev[1]);
    tick_wait(4);
    check_all("load_vs_step_settle");

    tick_wait(1);
    for (int i = 0; i < 10; i++) begin
      INC_KEY = ~INC_KEY;
      tick_wait(1);
    end
    INC_KEY = 1'b1;
    tick_wait(4);
    check_all("bounce");

    for (int k = 0; k < 12; k++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        lv = int'($urandom_range(0, 255));
        do_load(lv);
      end else begin
        tap(op == 1, int'($urandom_range(1, 14)));
      end
      check_all("random");
    end

    do_load(11);
    tick_wait(1);
    INC_KEY = 1'b0;
    tick_wait(5);
    m_step(1'b1);
    chk("pre_reset0", int'(value0), ev[0]);
    RESET_N = 1'b0;
    #1;
    ev[0] = DEFV;
    ev[1] = DEFV;
    chk("reset_hold0", int'(value0), DEFV);
    chk("reset_hold1", int'(value1), DEFV);
    chk("reset_hold_changed", int'(changed0), 0);
    repeat (2) @(posedge clk);
    #1;
    RESET_N = 1'b1;
    tick_wait(1);
    chk("rearm_wait0", int'(value0), DEFV);
    tick_wait(1);
    INC_KEY = 1'b1;
    m_step(1'b1);
    tick_wait(4);
    check_all("rearm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/setting_manager.md
Name: setting_manager

Overview:
- Parametrised successor to the single-register LED "full-on" setting manager.
- Holds one WIDTH-bit user setting adjusted by two active-low pushbuttons, on a single system clock with an internal tick prescaler.
- Adds debouncing, hold-to-auto-repeat, configurable range and step, an optional wrap mode, both-keys restore-default, and an external load port.
- Feeds brightness or threshold registers; 7-segment display of the value is done outside this block.

Parameters:
WIDTH, 8, setting width in bits
MIN_VAL, 0, lowest legal value
MAX_VAL, 255, highest legal value (MIN_VAL < MAX_VAL <= 2^WIDTH-1)
DEFAULT_VAL, 255, reset/restore value (MIN_VAL..MAX_VAL)
STEP, 1, increment/decrement size (1..MAX_VAL-MIN_VAL)
TICK_DIV, 50000, clk cycles per tick (>=2)
DEBOUNCE_TICKS, 10, consecutive stable ticks needed to accept a key change
REPEAT_DELAY, 500, ticks held before auto-repeat starts
REPEAT_RATE, 100, ticks between auto-repeat steps
WRAP, 0, 0 = saturate at the range limits, 1 = wrap to the opposite limit

Ports:
clk  input  1  system clock
RESET_N  input  1  asynchronous active-low reset
INC_KEY  input  1  raw increment pushbutton, active-low, asynchronous
DEC_KEY  input  1  raw decrement pushbutton, active-low, asynchronous
LOAD  input  1  synchronous load strobe, active-high
LOAD_VAL  input  WIDTH  value written when LOAD=1
value  output  WIDTH  current setting
at_min  output  1  value == MIN_VAL
at_max  output  1  value == MAX_VAL
changed  output  1  one-cycle pulse when value changes

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - value = DEFAULT_VAL, changed = 0.
  - Prescaler, debounce counters and FSM all cleared.
  - Debounced keys read as released.
  - at_min and at_max are combinational from value.
- Synchronizer: each key passes through a 2-flop synchronizer before debouncing.
- Prescaler: tick is a one-clk pulse every TICK_DIV cycles. Debounce and repeat counters advance only on tick.
- Debounce, per key:
  - If the synchronized level differs from the debounced level for DEBOUNCE_TICKS consecutive ticks, the debounced level flips.
  - Any tick where the two agree clears that key's counter.
- FSM, evaluated on tick:
  - IDLE:
    - inc only pressed → step up, go to WAIT.
    - dec only pressed → step down, go to WAIT.
    - both pressed → value = DEFAULT_VAL, go to LOCK.
  - WAIT: count REPEAT_DELAY ticks, then step and go to REPEAT.
  - REPEAT: step every REPEAT_RATE ticks.
  - WAIT and REPEAT exits:
    - Active key released → IDLE.
    - Other key also pressed → value = DEFAULT_VAL, go to LOCK.
  - LOCK: no action until both keys are released, then IDLE. No step is taken on a partial release.
- Step arithmetic, computed at WIDTH+1 bits with no overflow:
  - Up: if value+STEP > MAX_VAL then result = (WRAP ? MIN_VAL : MAX_VAL), else value+STEP.
  - Down: if value < MIN_VAL+STEP then result = (WRAP ? MAX_VAL : MIN_VAL), else value-STEP.
  - Wrap applies only when the value sits exactly at the limit. Otherwise the step clamps to the limit first.
- LOAD:
  - Highest priority; takes effect at the next clk edge, independent of tick.
  - value = LOAD_VAL clamped into [MIN_VAL, MAX_VAL].
  - A LOAD coinciding with a tick step wins. The FSM state and counters are unaffected.
- changed:
  - Asserted for exactly one clk when the registered value differs from its previous value.
  - A saturating step at a limit and a restore to an equal value produce no pulse.
- Latency: from the debounced press tick, value updates at the same clk edge as that tick. From the raw key edge, it is 2 clk plus DEBOUNCE_TICKS ticks.
- Reset mid-hold: value returns to DEFAULT_VAL. A key still held after release of reset must debounce again before it causes a first step.

Decomposition:
- Shared package: FSM state encoding (IDLE, WAIT, REPEAT, LOCK) and a counter-width helper (clog2).
- One sub-module, key_debouncer: synchronizer plus debounce counter, tick input, debounced level output. Instantiated twice.

Test Plan:
Small parameters for all scenarios: WIDTH=8, MIN=10, MAX=20, DEFAULT=15, STEP=3, TICK_DIV=4, DEBOUNCE_TICKS=2, REPEAT_DELAY=8, REPEAT_RATE=2.
1. Reset, then single INC press held for 4 ticks, then released → value 15→18, changed pulses once, no repeat.
2. INC held 30 ticks, WRAP=0 → 18, 20 after the delay, then steady at 20. at_max=1. changed pulses only on the 15→18 and 18→20 steps.
3. WRAP=1, value=20, INC press → value=10, at_min=1. Then DEC press → value=20.
4. Value 12, DEC held then INC added → value=15 (restore) while in LOCK. Release INC only → value stays 15. Release both → IDLE.
5. LOAD with LOAD_VAL=250 → value=20. LOAD with LOAD_VAL=3 → value=10. A LOAD on the same cycle as a repeat step → the load value wins.
6. Key bounce: INC toggles every tick for 10 ticks, then release → value unchanged, no changed pulse. RESET_N asserted while INC is held → value=15 immediately.
